// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back arbiter bus bundle
// Groups pipeline, B unit, decode and register-file port signals.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_hold;
  logic        a_drop;
  logic        b_issue;
  logic [4:0]  b_issue_addr;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        rd_hazard;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  a_valid, a_addr, a_data, b_issue, b_issue_addr,
           b_valid, b_addr, b_data, rd_addr1, rd_addr2,
    output a_hold, a_drop, b_ready, rd_hazard, wr_en, wr_addr, wr_data
  );

  modport master (
    output a_valid, a_addr, a_data, b_issue, b_issue_addr,
           b_valid, b_addr, b_data, rd_addr1, rd_addr2,
    input  a_hold, a_drop, b_ready, rd_hazard, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with busy scoreboard
// A has fixed priority; B gets a forced grant after STARVE_LIMIT lost cycles.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 clk_reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] FORCE_B = 1'b1;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  logic [0:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] busy, busy_nxt;
  logic        a_drop_q;
  logic        wr_en_q, wr_en_nxt;
  logic [4:0]  wr_addr_q, wr_addr_nxt;
  logic [31:0] wr_data_q, wr_data_nxt;
  logic        force_b, b_ready, b_acc, a_win;
  logic        hz1, hz2;

  assign force_b = (state == FORCE_B);
  assign b_ready = force_b | ~bus.a_valid;
  assign b_acc   = bus.b_valid & b_ready;
  assign a_win   = ~force_b & bus.a_valid;

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    // Leaving FORCE_B always restarts the count, even on a protocol-error exit.
    if (b_acc || force_b) begin
      cnt_nxt = 4'd0;
    end else if (bus.b_valid && cnt != LIMIT) begin
      cnt_nxt = cnt + 4'd1;
    end
    if (force_b) begin
      state_nxt = NORMAL;
    end else if (bus.b_valid && !b_ready && cnt_nxt == LIMIT) begin
      state_nxt = FORCE_B;
    end
  end

  always_comb begin
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    if (a_win) begin
      wr_en_nxt   = (bus.a_addr != 5'd0);
      wr_addr_nxt = bus.a_addr;
      wr_data_nxt = bus.a_data;
    end else if (b_acc) begin
      wr_en_nxt   = (bus.b_addr != 5'd0);
      wr_addr_nxt = bus.b_addr;
      wr_data_nxt = bus.b_data;
    end
  end

  // Clear before set so a same-cycle issue to the accepted register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (b_acc) begin
      busy_nxt[bus.b_addr] = 1'b0;
    end
    if (bus.b_issue && bus.b_issue_addr != 5'd0) begin
      busy_nxt[bus.b_issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clk_reset) begin
    if (clk_reset) begin
      state     <= NORMAL;
      cnt       <= 4'd0;
      busy      <= 32'd0;
      a_drop_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      a_drop_q  <= force_b & bus.a_valid;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
    end
  end

  // The wr_en term covers the cycle between accept and register-file update.
  assign hz1 = (bus.rd_addr1 != 5'd0) &&
               (busy[bus.rd_addr1] || (wr_en_q && wr_addr_q == bus.rd_addr1));
  assign hz2 = (bus.rd_addr2 != 5'd0) &&
               (busy[bus.rd_addr2] || (wr_en_q && wr_addr_q == bus.rd_addr2));

  assign bus.b_ready   = b_ready;
  assign bus.rd_hazard = hz1 | hz2;
  assign bus.a_hold    = force_b;
  assign bus.a_drop    = a_drop_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed bench for regfile_wb_arbiter
// Each task drives one scenario and checks hand-computed expectations inline.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic clk_reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .clk_reset (clk_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = 5'd0; bus.a_data = 32'd0;
    bus.b_issue = 1'b0; bus.b_issue_addr = 5'd0;
    bus.b_valid = 1'b0; bus.b_addr = 5'd0; bus.b_data = 32'd0;
    bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_bus got=%h/%h exp=0/0", bus.wr_addr, bus.wr_data); end
    checks++; if (bus.a_hold !== 1'b0 || bus.a_drop !== 1'b0) begin failures++; $display("FAIL reset_hold_drop got=%b%b exp=00", bus.a_hold, bus.a_drop); end
    tick();
    clk_reset = 1'b0;
    tick();
  endtask

  task automatic test_a_only();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
    tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'h1234) begin
      failures++; $display("FAIL a_write got=%b/%0d/%h exp=1/5/1234", bus.wr_en, bus.wr_addr, bus.wr_data); end
    bus.a_addr = 5'd0; bus.a_data = 32'h5678;
    tick();
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL a_write_r0 got=%b exp=0", bus.wr_en); end
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h1111;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.b_ready !== 1'b0 || bus.a_hold !== 1'b0) begin
        failures++; $display("FAIL cont_lose%0d ready/hold got=%b%b exp=00", i, bus.b_ready, bus.a_hold); end
      tick();
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd1) begin
        failures++; $display("FAIL cont_a_wr%0d got=%b/%0d exp=1/1", i, bus.wr_en, bus.wr_addr); end
    end
    #1;
    checks++; if (bus.a_hold !== 1'b1 || bus.b_ready !== 1'b1) begin
      failures++; $display("FAIL cont_force hold/ready got=%b%b exp=11", bus.a_hold, bus.b_ready); end
    tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9 || bus.wr_data !== 32'hBEEF) begin
      failures++; $display("FAIL cont_b_wr got=%b/%0d/%h exp=1/9/beef", bus.wr_en, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.a_drop !== 1'b1 || bus.a_hold !== 1'b0) begin
      failures++; $display("FAIL cont_drop drop/hold got=%b%b exp=10", bus.a_drop, bus.a_hold); end
    bus.b_valid = 1'b0;
    tick();
    checks++; if (bus.a_drop !== 1'b0 || bus.wr_addr !== 5'd1 || bus.wr_data !== 32'h1111) begin
      failures++; $display("FAIL cont_after drop/addr got=%b/%0d exp=0/1", bus.a_drop, bus.wr_addr); end
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    bus.b_issue = 1'b1; bus.b_issue_addr = 5'd7; bus.rd_addr1 = 5'd7;
    #1;
    checks++; if (bus.rd_hazard !== 1'b0) begin failures++; $display("FAIL sb_pre_issue got=%b exp=0", bus.rd_hazard); end
    tick();
    bus.b_issue = 1'b0;
    #1;
    checks++; if (bus.rd_hazard !== 1'b1) begin failures++; $display("FAIL sb_busy got=%b exp=1", bus.rd_hazard); end
    bus.rd_addr1 = 5'd0;
    #1;
    checks++; if (bus.rd_hazard !== 1'b0) begin failures++; $display("FAIL sb_r0 got=%b exp=0", bus.rd_hazard); end
    bus.rd_addr2 = 5'd7;
    #1;
    checks++; if (bus.rd_hazard !== 1'b1) begin failures++; $display("FAIL sb_port2 got=%b exp=1", bus.rd_hazard); end
    bus.rd_addr2 = 5'd0; bus.rd_addr1 = 5'd7;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h77;
    #1;
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("FAIL sb_accept_ready got=%b exp=1", bus.b_ready); end
    tick();
    bus.b_valid = 1'b0;
    #1;
    checks++; if (bus.rd_hazard !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7) begin
      failures++; $display("FAIL sb_t1 hz/en/addr got=%b/%b/%0d exp=1/1/7", bus.rd_hazard, bus.wr_en, bus.wr_addr); end
    tick();
    checks++; if (bus.rd_hazard !== 1'b0) begin failures++; $display("FAIL sb_t2 got=%b exp=0", bus.rd_hazard); end
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    bus.b_issue = 1'b1; bus.b_issue_addr = 5'd3; bus.rd_addr1 = 5'd3;
    tick();
    bus.b_valid = 1'b1; bus.b_addr = 5'd3; bus.b_data = 32'h33;
    tick();
    bus.b_issue = 1'b0; bus.b_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.rd_hazard !== 1'b1) begin failures++; $display("FAIL sim_set_wins got=%b exp=1", bus.rd_hazard); end
    bus.b_valid = 1'b1;
    tick();
    bus.b_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.rd_hazard !== 1'b0) begin failures++; $display("FAIL sim_cleared got=%b exp=0", bus.rd_hazard); end
    bus.b_issue = 1'b1; bus.b_issue_addr = 5'd0; bus.rd_addr1 = 5'd0;
    tick();
    bus.b_issue = 1'b0;
    #1;
    checks++; if (bus.rd_hazard !== 1'b0) begin failures++; $display("FAIL sim_issue_r0 got=%b exp=0", bus.rd_hazard); end
    idle_inputs();
    tick();
  endtask

  task automatic test_idle_b();
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h55;
    #1;
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", bus.b_ready); end
    tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd4 || bus.wr_data !== 32'h55 || bus.a_hold !== 1'b0) begin
      failures++; $display("FAIL idle_wr got=%b/%0d/%h hold=%b exp=1/4/55 hold=0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.a_hold); end
    bus.b_addr = 5'd0;
    tick();
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL idle_b_r0 got=%b exp=0", bus.wr_en); end
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd2; bus.a_data = 32'h2;
    bus.b_valid = 1'b1; bus.b_addr = 5'd6;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.a_hold !== 1'b0) begin failures++; $display("FAIL idle_cnt_zero hold got=%b exp=0", bus.a_hold); end
    tick();
    checks++; if (bus.a_hold !== 1'b1) begin failures++; $display("FAIL idle_cnt_limit hold got=%b exp=1", bus.a_hold); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.b_issue = 1'b1; bus.b_issue_addr = 5'd10; bus.rd_addr1 = 5'd10;
    tick();
    bus.b_issue = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd8; bus.a_data = 32'hCAFE;
    bus.b_valid = 1'b1; bus.b_addr = 5'd10; bus.b_data = 32'hF00D;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.a_hold !== 1'b1 || bus.wr_en !== 1'b1) begin
      failures++; $display("FAIL rmid_pre hold/en got=%b%b exp=11", bus.a_hold, bus.wr_en); end
    #2;
    clk_reset = 1'b1;
    #1;
    checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin
      failures++; $display("FAIL rmid_wr got=%b/%0d/%h exp=0/0/0", bus.wr_en, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.a_hold !== 1'b0 || bus.a_drop !== 1'b0) begin
      failures++; $display("FAIL rmid_hold_drop got=%b%b exp=00", bus.a_hold, bus.a_drop); end
    checks++; if (bus.rd_hazard !== 1'b0) begin failures++; $display("FAIL rmid_hazard got=%b exp=0", bus.rd_hazard); end
    idle_inputs();
    tick();
    clk_reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_contention();
    test_scoreboard();
    test_simultaneous();
    test_idle_b();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
